// File: rtl/serial_shifter_if.sv
// serial_shifter_if: request/result bundle between a shift requester and the shifter
interface serial_shifter_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    modport master(output start, op, a, shamt, input busy, done, y);
    modport slave(input start, op, a, shamt, output busy, done, y);
endinterface

// File: rtl/serial_shifter.sv
// serial_shifter: one-bit-per-cycle shifter/rotator with start/busy/done handshake
module serial_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic              clk,
    input logic              reset_n,
    serial_shifter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] stepped;
    logic [SHW-1:0]   count;
    logic [1:0]       mode;
    logic             busy_flag;
    logic             done_flag;
    // one-bit step of the latched operation: 00 sll, 01 srl, 11 sra, 10 ror
    always_comb begin
        stepped = mode == 2'b00 ? {result[WIDTH-2:0], 1'b0} :
                  mode == 2'b01 ? {1'b0, result[WIDTH-1:1]} :
                  mode == 2'b11 ? {result[WIDTH-1], result[WIDTH-1:1]} :
                                  {result[0], result[WIDTH-1:1]};
    end
    // control FSM with registered busy/done; accepts only from IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            result    <= '0;
            count     <= '0;
            mode      <= 2'b00;
            busy_flag <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    result    <= bus.a;
                    mode      <= bus.op;
                    count     <= bus.shamt;
                    busy_flag <= 1'b1;
                    done_flag <= bus.shamt == '0;
                    state     <= bus.shamt == '0 ? DONE : SHIFT;
                end
                SHIFT: begin
                    result <= stepped;
                    if (count != '0) count <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        state     <= DONE;
                        done_flag <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy_flag <= 1'b0;
                    done_flag <= 1'b0;
                end
            endcase
        end
    end
    assign bus.y    = result;
    assign bus.busy = busy_flag;
    assign bus.done = done_flag;
endmodule
